// File: rtl/axil_rr_arbiter.sv
// axil_rr_arbiter: two-requester round-robin front end
// sharing one AXI4-Lite master port, one transaction at a time.
module axil_rr_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req0_valid,
  input  logic                req0_write,
  input  logic [ADDR_W-1:0]   req0_addr,
  input  logic [DATA_W-1:0]   req0_wdata,
  input  logic [DATA_W/8-1:0] req0_wstrb,
  output logic                req0_done,
  output logic [DATA_W-1:0]   req0_rdata,
  output logic [1:0]          req0_resp,
  input  logic                req1_valid,
  input  logic                req1_write,
  input  logic [ADDR_W-1:0]   req1_addr,
  input  logic [DATA_W-1:0]   req1_wdata,
  input  logic [DATA_W/8-1:0] req1_wstrb,
  output logic                req1_done,
  output logic [DATA_W-1:0]   req1_rdata,
  output logic [1:0]          req1_resp,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [2:0]          m_awprot,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [2:0]          m_arprot,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rvalid,
  output logic                m_rready
);

  localparam int SW = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              last;
  logic              gnt;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdat;
  logic [SW-1:0]     wstrb;
  logic [1:0]        rsp;
  logic              el0;
  logic              el1;
  logic              any;
  logic              pick;
  logic              pick_wr;
  logic              aw_ok;
  logic              w_ok;

  // a requester still showing its done pulse holds the old request
  assign el0     = req0_valid & ~req0_done;
  assign el1     = req1_valid & ~req1_done;
  assign any     = el0 | el1;
  assign pick    = el1 & (~el0 | ~last);
  assign pick_wr = pick ? req1_write : req0_write;
  assign aw_ok   = ~m_awvalid | m_awready;
  assign w_ok    = ~m_wvalid | m_wready;

  assign m_awaddr = addr;
  assign m_araddr = addr;
  assign m_wdata  = wdata;
  assign m_wstrb  = wstrb;
  assign m_awprot = 3'b000;
  assign m_arprot = 3'b000;

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any) state_nxt = pick_wr ? WR_ADDR : RD_ADDR;
      WR_ADDR: if (aw_ok && w_ok) state_nxt = WR_RESP;
      WR_RESP: if (m_bvalid) state_nxt = DONE;
      RD_ADDR: if (m_arready) state_nxt = RD_DATA;
      RD_DATA: if (m_rvalid) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // registered channel controls, request latch and completion outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      last       <= 1'b1;
      gnt        <= 1'b0;
      wr         <= 1'b0;
      addr       <= '0;
      wdata      <= '0;
      wstrb      <= '0;
      rdat       <= '0;
      rsp        <= '0;
      m_awvalid  <= 1'b0;
      m_wvalid   <= 1'b0;
      m_arvalid  <= 1'b0;
      m_bready   <= 1'b0;
      m_rready   <= 1'b0;
      req0_done  <= 1'b0;
      req0_rdata <= '0;
      req0_resp  <= '0;
      req1_done  <= 1'b0;
      req1_rdata <= '0;
      req1_resp  <= '0;
    end else begin
      req0_done <= 1'b0;
      req1_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any) begin
            gnt       <= pick;
            wr        <= pick_wr;
            addr      <= pick ? req1_addr : req0_addr;
            wdata     <= pick ? req1_wdata : req0_wdata;
            wstrb     <= pick ? req1_wstrb : req0_wstrb;
            m_awvalid <= pick_wr;
            m_wvalid  <= pick_wr;
            m_arvalid <= ~pick_wr;
          end
        end
        WR_ADDR: begin
          if (m_awready) m_awvalid <= 1'b0;
          if (m_wready) m_wvalid <= 1'b0;
          if (aw_ok && w_ok) m_bready <= 1'b1;
        end
        WR_RESP: begin
          if (m_bvalid) begin
            m_bready <= 1'b0;
            rsp      <= m_bresp;
          end
        end
        RD_ADDR: begin
          if (m_arready) begin
            m_arvalid <= 1'b0;
            m_rready  <= 1'b1;
          end
        end
        RD_DATA: begin
          if (m_rvalid) begin
            m_rready <= 1'b0;
            rsp      <= m_rresp;
            rdat     <= m_rdata;
          end
        end
        DONE: begin
          last <= gnt;
          if (gnt) begin
            req1_done  <= 1'b1;
            req1_resp  <= rsp;
            req1_rdata <= wr ? '0 : rdat;
          end else begin
            req0_done  <= 1'b1;
            req0_resp  <= rsp;
            req0_rdata <= wr ? '0 : rdat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
